// File: rtl/mem_responder.sv
// mem_responder: CPU load/store front end for a synchronous word RAM.
module mem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);
  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;
  state_t state, state_nx;
  logic              we_q, signed_q, err_q, req_err, accept;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       buf_q, rdata_q, load_val, merged;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  assign accept = state == IDLE && req_valid;
  assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign ram_en = state == RD || state == WR;
  assign ram_we = state == WR;
  assign ram_addr = addr_q[ADDR_W+1:2];
  assign ram_din = state == WR ? buf_q : 32'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = req_err ? RESP : (req_we && req_size == 2'b10) ? WR : RD;
      RD:   state_nx = DATA;
      DATA: state_nx = we_q ? WR : RESP;
      WR:   state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    lane_b = ram_dout[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    load_val = size_q == 2'b00 ? {{24{signed_q & lane_b[7]}}, lane_b} :
               size_q == 2'b01 ? {{16{signed_q & lane_h[15]}}, lane_h} : ram_dout;
    merged = ram_dout;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = buf_q[7:0];
    else if (size_q == 2'b01) merged[{addr_q[1], 4'b0000} +: 16] = buf_q[15:0];
    else merged = buf_q;
  end
  // buf_q holds raw store data until DATA, then the merged word to write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q <= 1'b0;
      signed_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      buf_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q <= 1'b0;
    end else if (accept) begin
      we_q <= req_we;
      signed_q <= req_signed;
      size_q <= req_size;
      addr_q <= req_addr[ADDR_W+1:0];
      buf_q <= req_wdata;
      rdata_q <= 32'h0;
      err_q <= req_err;
    end else if (state == DATA) begin
      if (we_q) buf_q <= merged;
      else rdata_q <= load_val;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, word-address width of attached RAM (capacity 2^ADDR_W words).
REQ-002 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  CPU request present.
REQ-005 SHALL have port: req_ready  output  1  block can accept a request.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port: req_signed  input  1  sign-extend load result (byte/half only).
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port: rsp_valid  output  1  response present.
REQ-012 SHALL have port: rsp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port: rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port: rsp_err  output  1  request rejected (misaligned/out of range/reserved size).
REQ-015 SHALL have ports: ram_en output 1 / ram_we output 1 / ram_addr output ADDR_W / ram_din output 32 / ram_dout input 32; synchronous RAM, ram_dout valid the cycle after ram_en with ram_we=0.

Function
REQ-016 SHALL implement FSM states IDLE, RD, DATA, WR, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL latch we/size/signed/addr/wdata on the IDLE cycle where req_valid=1; inputs ignored afterwards.
REQ-018 SHALL flag error when: size=11; size=01 and addr[0]=1; size=10 and addr[1:0]!=0; addr[31:ADDR_W+2]!=0. Error: IDLE->RESP, rsp_err=1, rsp_rdata=0, no RAM access.
REQ-019 SHALL route: load or byte/half store IDLE->RD; word store IDLE->WR.
REQ-020 SHALL in RD drive ram_en=1, ram_we=0, ram_addr=addr[ADDR_W+1:2]; RD->DATA unconditionally.
REQ-021 SHALL in DATA for loads register extracted ram_dout into rsp_rdata and go RESP; for stores register merged word into write buffer and go WR.
REQ-022 SHALL use little-endian lanes: byte lane addr[1:0] (lane 0 = bits 7:0); half lane addr[1] (0 = bits 15:0).
REQ-023 SHALL zero-extend byte/half loads when req_signed=0, sign-extend when 1; word loads return ram_dout unchanged (req_signed ignored).
REQ-024 SHALL merge stores by replacing only the addressed lane(s) of ram_dout with wdata[7:0] or wdata[15:0]; word store writes wdata directly.
REQ-025 SHALL in WR drive ram_en=1, ram_we=1, ram_addr, ram_din=buffer (exactly one cycle); WR->RESP.
REQ-026 SHALL in RESP hold rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1; on that edge go IDLE and clear rsp_valid.
REQ-027 SHALL give latency (accept edge = T): error rsp_valid at T+1; word store T+2; load T+3; byte/half store T+3 write, T+4 rsp_valid.
REQ-028 SHALL not accept a new request in the cycle a response completes (one idle cycle with req_ready=1 before next accept).
REQ-029 SHALL drive ram_en=ram_we=0 in IDLE, DATA, RESP; ram_din=0 outside WR.

Reset
REQ-030 SHALL on rst_n=0 immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, buffers 0.
REQ-031 SHALL abort any in-flight request on reset, including a WR cycle (ram_we drops asynchronously); no response is issued for it.

Verification
REQ-032 SHALL cover: RAM[0x10>>2]=0x11223344, lw 0x10 -> rsp_valid at T+3, rsp_rdata=0x11223344, rsp_err=0.
REQ-033 SHALL cover: RAM word 0x8899AABB at 0x20; lb 0x23 signed -> 0xFFFFFF88; lbu 0x23 -> 0x00000088; lh 0x20 signed -> 0xFFFFAABB; lhu 0x22 -> 0x00008899.
REQ-034 SHALL cover: sb 0x11 wdata 0x000000EE onto 0x11223344 -> ram_we at T+3 with ram_din=0x1122EE44, rsp_valid T+4, rdata 0; sw 0x14 wdata 0xCAFEF00D -> ram_we at T+1, rsp_valid T+2.
REQ-035 SHALL cover: sh 0x11, lw 0x12, size=11, lw 0x1000 (ADDR_W=10) -> each rsp_err=1 at T+1, ram_en never asserted.
REQ-036 SHALL cover: load with rsp_ready=0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; completes on first rsp_ready=1 edge.
REQ-037 SHALL cover: rst_n asserted during WR -> ram_we=0 and rsp_valid=0 same cycle, req_ready=1, no response after release.
